// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-access target.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

    // Bus-side protocol FSM states
    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_state_e;

    // Level on SDA during the acknowledge bit
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Address this target answers to unless overridden
    localparam logic [6:0] DEF_TARGET_ADDR = 7'h50;

    // clk must run at least this many times faster than SCL: the pad-to-event
    // path is 3 clk, and SDA must be settled and re-synchronised well inside
    // each SCL phase for START/STOP to be told apart from data.
    localparam int unsigned OVERSAMPLE_MIN = 8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser and edge detector for one asynchronous open-drain pad line.
// Latency: pad change to level/edge seen by the consumer's registers is 3 clk.
// Backpressure: none; free-running on every clk.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-flop synchroniser plus one history flop; resets to the idle-bus level
    // so releasing reset never fabricates an edge on a quiet bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pad_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target bridging 7-bit-address pointer write/read transactions to a byte register file.
// Latency: bus events act 3 clk after the pad; sda_oe updates 1 clk after a detected SCL fall.
// Backpressure: none; no clock stretching, register file must answer combinationally.
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = i2c_pkg::DEF_TARGET_ADDR,
    parameter int unsigned REG_AW      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);
    import i2c_pkg::*;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .pad_i   (scl_in),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .rst     (rst),
        .pad_i   (sda_in),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_e        state_q, state_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shift_q, shift_d;
    // done_q: byte received (waiting for the SCL fall that opens the ACK slot),
    // or in RDATA_ACK: controller ACK seen (waiting for the fall to load next byte)
    logic              done_q, done_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic              reg_we_q, reg_we_d;

    logic [7:0] rx_byte;
    assign rx_byte = {shift_q[6:0], sda_lvl};

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bitcnt_q    <= 3'd7;
            shift_q     <= 8'h00;
            done_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
        end
    end

    // Next-state logic: bus conditions first, then per-state bit handling
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        done_d      = done_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;

        if (stop_det) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            done_d   = 1'b0;
        end else if (start_det) begin
            // Covers repeated START too; pointer is deliberately kept
            state_d  = ADDR;
            busy_d   = 1'b1;
            sda_oe_d = 1'b0;
            bitcnt_d = 3'd7;
            done_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && !done_q) begin
                        shift_d  = rx_byte;
                        bitcnt_d = bitcnt_q - 3'd1;
                        if (bitcnt_q == 3'd0) begin
                            done_d = 1'b1;
                            if (state_q == PTR) begin
                                reg_addr_d = rx_byte[REG_AW-1:0];
                            end
                            if (state_q == WDATA) begin
                                reg_wdata_d = rx_byte;
                                reg_we_d    = 1'b1;
                            end
                        end
                    end else if (scl_fall && done_q) begin
                        done_d   = 1'b0;
                        sda_oe_d = (ACK == 1'b0);
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                state_d = ADDR_ACK;
                            end else begin
                                state_d  = IGNORE;
                                sda_oe_d = 1'b0;
                            end
                        end else if (state_q == PTR) begin
                            state_d = PTR_ACK;
                        end else begin
                            state_d = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bitcnt_d = 3'd7;
                        if (shift_q[0]) begin
                            shift_d  = reg_rdata;
                            sda_oe_d = ~reg_rdata[7];
                            state_d  = RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = PTR;
                        end
                    end
                end
                PTR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = 3'd7;
                        state_d  = WDATA;
                    end
                end
                WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d   = 1'b0;
                        bitcnt_d   = 3'd7;
                        reg_addr_d = reg_addr_q + REG_AW'(1);
                        state_d    = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            done_d   = 1'b0;
                            state_d  = RDATA_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise && !done_q) begin
                        if (sda_lvl == ACK) begin
                            // Advance now so reg_rdata is settled by the next fall
                            done_d     = 1'b1;
                            reg_addr_d = reg_addr_q + REG_AW'(1);
                        end else begin
                            state_d = IGNORE;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d   = 1'b0;
                        shift_d  = reg_rdata;
                        sda_oe_d = ~reg_rdata[7];
                        bitcnt_d = 3'd7;
                        state_d  = RDATA;
                    end
                end
                default: begin
                    // IDLE and IGNORE: SCL activity has no effect
                end
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;

endmodule
